// File: rtl/maxpool2x2_stream_pooler.sv
// Purpose: 2x2 / stride-2 max pooling of a row-major pixel stream, one pooled maximum per window.
// Latency: the result is registered on the edge that accepts the window's 4th pixel and is valid the next cycle.
// Backpressure: one output register; input stalls (In_Ready low) while a result is held and Out_Ready is low.
module maxpool2x2_stream_pooler #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Clr,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  Out_Last,
    output logic                  Busy
);

    localparam int COL_W  = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int HALF_W = IMG_WIDTH / 2;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] pair_q, pair_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_vld_q, out_vld_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;

    // Horizontal pair maxima of the even row, indexed by output column.
    logic [DATA_WIDTH-1:0] line_buf [HALF_W];

    logic                  accept;
    logic                  out_take;
    logic                  col_end;
    logic                  row_end;
    logic                  phase1;
    logic                  row_odd;
    logic                  buf_wr;
    logic [IDX_W-1:0]      buf_idx;
    logic signed [DATA_WIDTH-1:0] pm;
    logic signed [DATA_WIDTH-1:0] win_max;

    assign In_Ready = !out_vld_q || Out_Ready;
    // Clr wins over a transfer: nothing is accepted on a clearing cycle.
    assign accept   = In_Valid && In_Ready && !Clr;
    assign out_take = out_vld_q && Out_Ready;
    assign col_end  = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_end  = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign phase1   = col_q[0];
    assign row_odd  = row_q[0];
    assign buf_idx  = IDX_W'(col_q >> 1);
    assign buf_wr   = accept && phase1 && !row_odd;

    assign Out_Data  = out_data_q;
    assign Out_Valid = out_vld_q;
    assign Out_Last  = out_last_q;
    assign Busy      = busy_q;

    // Signed maxima: pair max of the current row, then against the stored even-row pair max.
    always_comb begin
        pm = $signed(pair_q);
        if ($signed(In_Data) > pm) begin
            pm = $signed(In_Data);
        end
        win_max = $signed(line_buf[buf_idx]);
        if (pm > win_max) begin
            win_max = pm;
        end
    end

    // Column/row position and first-of-pair capture; only accepted pixels advance them.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        pair_d = pair_q;
        if (Clr) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (!phase1) begin
                pair_d = In_Data;
            end
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Output register and frame-busy tracking; a load on the draining edge keeps the output valid.
    always_comb begin
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        busy_d     = busy_q;
        if (out_take) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
            if (out_last_q) begin
                busy_d = 1'b0;
            end
        end
        if (accept) begin
            busy_d = 1'b1;
            if (phase1 && row_odd) begin
                out_data_d = win_max;
                out_vld_d  = 1'b1;
                out_last_d = col_end && row_end;
            end
        end
        if (Clr) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
            busy_d     = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col_q      <= '0;
            row_q      <= '0;
            pair_q     <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            pair_q     <= pair_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            busy_q     <= busy_d;
        end
    end

    // Line buffer needs no reset: every entry is written on the even row before the odd row reads it.
    always_ff @(posedge Clk) begin
        if (buf_wr) begin
            line_buf[buf_idx] <= pm;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream_pooler.sv
module tb_maxpool2x2_stream_pooler;

    typedef struct {
        logic [31:0] dat;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        sel;          // 0: 4x4 instance, 1: 8x8 instance
    logic [31:0] in_dat;
    logic        in_vld;
    logic        out_rdy;
    int          rdy_mode;     // 0: always ready, 1: never ready, 2: random

    logic        in_rdy4, in_rdy8, out_vld4, out_vld8, out_last4, out_last8, busy4, busy8;
    logic [31:0] out_dat4, out_dat8;
    logic        in_vld4, in_vld8;
    logic        in_rdy, out_vld, out_last, busy;
    logic [31:0] out_dat;

    exp_t        exp_q[$];
    logic [31:0] frame [64];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;

    always #5 clk = ~clk;

    assign in_vld4  = in_vld && !sel;
    assign in_vld8  = in_vld && sel;
    assign in_rdy   = sel ? in_rdy8   : in_rdy4;
    assign out_vld  = sel ? out_vld8  : out_vld4;
    assign out_dat  = sel ? out_dat8  : out_dat4;
    assign out_last = sel ? out_last8 : out_last4;
    assign busy     = sel ? busy8     : busy4;

    maxpool2x2_stream_pooler #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .Clk(clk), .Rst(rst_n), .Clr(clr),
        .In_Data(in_dat), .In_Valid(in_vld4), .In_Ready(in_rdy4),
        .Out_Data(out_dat4), .Out_Valid(out_vld4), .Out_Ready(out_rdy),
        .Out_Last(out_last4), .Busy(busy4)
    );

    maxpool2x2_stream_pooler #(.DATA_WIDTH(32), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
        .Clk(clk), .Rst(rst_n), .Clr(clr),
        .In_Data(in_dat), .In_Valid(in_vld8), .In_Ready(in_rdy8),
        .Out_Data(out_dat8), .Out_Valid(out_vld8), .Out_Ready(out_rdy),
        .Out_Last(out_last8), .Busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] smax(input logic [31:0] a, input logic [31:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Reference: every 2x2 window of the frame, row-major, last flag on the final window.
    task automatic build_expected(input int w, input int h);
        exp_t e;
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                e.dat  = smax(smax(frame[2*r*w + 2*c], frame[2*r*w + 2*c + 1]),
                              smax(frame[(2*r+1)*w + 2*c], frame[(2*r+1)*w + 2*c + 1]));
                e.last = (r == h / 2 - 1) && (c == w / 2 - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Ready generator for the output side.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = 1'b0;
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: a transfer happens on the coming edge when valid and ready are seen here.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_vld && out_rdy) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_out_vld", {31'd0, out_vld}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_dat", out_dat, e.dat);
                check("out_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    task automatic send_pixel(input logic [31:0] d, input bit gaps);
        int n = 0;
        if (gaps) begin
            for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++) begin
                @(posedge clk);
                #1;
            end
        end
        in_dat = d;
        in_vld = 1'b1;
        @(negedge clk);
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) check("in_rdy_timeout", {31'd0, in_rdy}, 32'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) send_pixel(frame[i], gaps);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_frame4();
        for (int i = 0; i < 16; i++) frame[i] = i;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int out_base;
        rst_n = 1'b0; clr = 1'b0; sel = 1'b0; in_vld = 1'b0; in_dat = '0; rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_vld", {31'd0, out_vld}, 32'd0);
        check("rst_out_dat", out_dat, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);

        // 4x4 ramp, always ready: 5, 7, 13, 15.
        ramp_frame4();
        build_expected(4, 4);
        send_pixel(frame[0], 1'b0);
        check("busy_after_first", {31'd0, busy}, 32'd1);
        send_range(1, 15, 1'b0);
        drain();
        check("t1_busy_idle", {31'd0, busy}, 32'd0);
        check("t1_out_vld_idle", {31'd0, out_vld}, 32'd0);

        // Signed compare, including the most negative value.
        for (int i = 0; i < 16; i++) frame[i] = $urandom;
        frame[0] = -32'sd3; frame[1] = -32'sd8; frame[4] = -32'sd1; frame[5] = -32'sd20;
        frame[2] = 32'h8000_0000; frame[3] = 32'h8000_0000;
        frame[6] = 32'h8000_0000; frame[7] = 32'h8000_0000;
        check("t2_model_neg", smax(smax(frame[0], frame[1]), smax(frame[4], frame[5])), 32'hFFFF_FFFF);
        build_expected(4, 4);
        send_range(0, 15, 1'b0);
        drain();

        // Backpressure on the first result.
        ramp_frame4();
        build_expected(4, 4);
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send_range(0, 5, 1'b0);
        @(negedge clk);
        check("t3_hold_vld", {31'd0, out_vld}, 32'd1);
        check("t3_hold_dat", out_dat, 32'd5);
        check("t3_in_rdy_low", {31'd0, in_rdy}, 32'd0);
        in_dat = frame[6];
        in_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_stable_dat", out_dat, 32'd5);
            check("t3_stable_vld", {31'd0, out_vld}, 32'd1);
        end
        rdy_mode = 0;
        send_range(6, 15, 1'b0);
        drain();
        check("t3_busy_idle", {31'd0, busy}, 32'd0);

        // Random gaps on both sides, three 8x8 frames.
        sel = 1'b1;
        rdy_mode = 2;
        out_base = n_out;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 64; i++) frame[i] = $urandom;
            build_expected(8, 8);
            send_range(0, 63, 1'b1);
        end
        drain();
        check("t4_out_count", n_out - out_base, 32'd48);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("t4_busy_idle", {31'd0, busy}, 32'd0);
        sel = 1'b0;

        // Clear with a pending result, then a clean frame.
        ramp_frame4();
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send_range(0, 5, 1'b0);
        check("t5_pending", {31'd0, out_vld}, 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("t5_clr_vld", {31'd0, out_vld}, 32'd0);
        check("t5_clr_busy", {31'd0, busy}, 32'd0);
        rdy_mode = 0;
        build_expected(4, 4);
        send_range(0, 15, 1'b0);
        drain();

        // Asynchronous reset mid row 1, then a clean frame.
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send_range(0, 5, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", {31'd0, out_vld}, 32'd0);
        check("t6_rst_dat", out_dat, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_last", {31'd0, out_last}, 32'd0);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        build_expected(4, 4);
        send_range(0, 15, 1'b0);
        drain();
        check("t6_busy_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
